multiport_memory_unit: RTL and testbench
========================================

# multiport_memory_unit

Parametrised, multi-requester successor to the single-client cell memory controller. It arbitrates NPORTS independent clients round-robin onto one external synchronous RAM and services four operations: read cell, write cell, allocate a contiguous free block, and set the free pointer. Out-of-memory is reported as an error, or optionally handed to a garbage-collector handshake, instead of halting. It sits between the Nock execution/traversal units and the RAM macro.

## Interface
- ADDR_W, 10, cell address width; RAM depth is 2**ADDR_W words
- DATA_W, 64, cell word width (tag plus two pointers)
- NPORTS, 2, number of requester ports (1..8)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NPORTS  per-port request, held until that port's done
- func  in  2*NPORTS  per-port op: 00 GET_CONTENTS, 01 SET_CONTENTS, 10 GET_FREE, 11 SET_FREE
- addr  in  NPORTS*ADDR_W  per-port cell address
- wdata  in  NPORTS*DATA_W  per-port write data; GET_FREE count / SET_FREE value in low ADDR_W bits
- done  out  NPORTS  one-cycle completion pulse to the granted port
- err  out  1  valid with done; 1 = allocation failed
- rdata  out  DATA_W  shared result: read word, or allocated base address (zero-extended)
- ready  out  1  high while in IDLE
- free_ptr  out  ADDR_W  current first free address
- mem_addr / mem_wren / mem_wdata  out  ADDR_W / 1 / DATA_W  RAM port, all registered
- mem_rdata  in  DATA_W  RAM q; 1-cycle synchronous read of mem_addr
- gc_req out 1, gc_done in 1  present only with MEM_UNIT_GC_REQ_EN

## Operation
- States: INIT_RD, INIT_WAIT, INIT_CLEAR, INIT_DONE, IDLE, READ_WAIT, READ_CAP, WRITE_DONE, ALLOC, GC_WAIT (macro only).
- Init: word 0 holds the free-pointer seed. INIT_RD -> INIT_WAIT -> INIT_CLEAR (free_ptr <= mem_rdata[ADDR_W-1:0]) -> INIT_DONE (mem_wren=1, mem_addr=0, mem_wdata=0) -> IDLE (mem_wren=0).
- Arbitration in IDLE: eligible = req & ~done. Search starts at last_grant+1 mod NPORTS; last_grant resets to NPORTS-1, so port 0 wins first. No eligible port: stay IDLE.
- GET_CONTENTS: mem_addr<=addr -> READ_WAIT -> READ_CAP (rdata<=mem_rdata, done) -> IDLE.
- SET_CONTENTS: mem_addr, mem_wdata, mem_wren=1 -> WRITE_DONE (mem_wren=0, done) -> IDLE.
- GET_FREE n: sum = {1'b0,free_ptr} + n in ADDR_W+1 bits. If sum <= 2**ADDR_W-1: rdata<=free_ptr, free_ptr<=sum, err=0. Else free_ptr unchanged, and behaviour follows Configuration. n=0 succeeds and returns free_ptr unchanged.
- SET_FREE: free_ptr<=wdata[ADDR_W-1:0], rdata<=0, err=0.
- err is 0 for all non-allocation completions.

## Timing
- Reset values: done=0, err=0, rdata=0, ready=0, free_ptr=0, mem_addr=0, mem_wren=0, mem_wdata=0, gc_req=0, state=INIT_RD. Reset mid-operation aborts the operation immediately; mem_wren drops asynchronously and init reruns.
- ready rises after the 4th rising edge following rst deassertion.
- Acceptance edge A is the IDLE edge that grants a port. done is high after edge A+2 for a read, and after A+1 for a write, GET_FREE, or SET_FREE. done lasts exactly one cycle, and rdata/err are valid with it.
- The next acceptance can occur on the edge at which done is high. The completing port is masked on that edge and must drop or renew req afterward.

## Configuration
- MEM_UNIT_GC_REQ_EN undefined: a failed GET_FREE completes at A+1 with done=1, err=1, rdata=0.
- MEM_UNIT_GC_REQ_EN defined: a failed GET_FREE enters GC_WAIT with gc_req=1 and holds the grant. On gc_done=1, gc_req drops and the allocation is retried against the current free_ptr. The GC updates free_ptr through SET_FREE on a port, which is serviced while in GC_WAIT. If the retry fails again, the block completes with err=1.

## Test plan
- Init: RAM word0=0x0123 with ADDR_W=10 -> after ready, free_ptr=0x123, word0 reads back 0, ready high at edge 4.
- Write 0xDEADBEEF to 0x050 then read 0x050 -> write done at A+1, read done at A+2 with rdata=0xDEADBEEF, err=0.
- free_ptr=0x100, GET_FREE n=4 twice -> rdata=0x100 then 0x104, free_ptr=0x108.
- free_ptr=0x3FE, GET_FREE n=2 -> err=1, free_ptr stays 0x3FE (macro off); with the macro on, gc_req rises, then SET_FREE 0x010 and gc_done -> rdata=0x010, free_ptr=0x012.
- NPORTS=2, both ports hold req for reads continuously -> grants alternate 0,1,0,1 and neither port starves.
- Assert rst while mem_wren=1 -> mem_wren=0 immediately, and the init sequence repeats.

Source files
------------

// File: rtl/multiport_memory_unit_if.sv
// Client-side bus of multiport_memory_unit: per-port request/op/address/data
// bundles in, per-port done pulses plus the shared err/rdata result out.
interface multiport_memory_unit_if #(
  parameter int unsigned NPORTS = 2,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 64
);
  logic [NPORTS-1:0]        req;
  logic [2*NPORTS-1:0]      func;
  logic [NPORTS*ADDR_W-1:0] addr;
  logic [NPORTS*DATA_W-1:0] wdata;
  logic [NPORTS-1:0]        done;
  logic                     err;
  logic [DATA_W-1:0]        rdata;

  modport master (output req, func, addr, wdata, input done, err, rdata);
  modport slave  (input req, func, addr, wdata, output done, err, rdata);
endinterface

// File: rtl/multiport_memory_unit.sv
// Round-robin multi-client cell memory controller over one synchronous RAM.
// Optional garbage-collector handshake on allocation failure: MEM_UNIT_GC_REQ_EN.
module multiport_memory_unit #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NPORTS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  multiport_memory_unit_if.slave bus,
  output logic                  ready,
  output logic [ADDR_W-1:0]     free_ptr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wren,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
`ifdef MEM_UNIT_GC_REQ_EN
  ,
  output logic                  gc_req,
  input  logic                  gc_done
`endif
);
  localparam int unsigned PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [1:0] OP_GET   = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_FREE  = 2'b11;

`ifdef MEM_UNIT_GC_REQ_EN
  typedef enum logic [3:0] {INIT_RD, INIT_WAIT, INIT_CLEAR, INIT_DONE, IDLE,
                            READ_WAIT, READ_CAP, WRITE_DONE, ALLOC, GC_WAIT} state_t;
`else
  typedef enum logic [3:0] {INIT_RD, INIT_WAIT, INIT_CLEAR, INIT_DONE, IDLE,
                            READ_WAIT, READ_CAP, WRITE_DONE, ALLOC} state_t;
`endif

  state_t              state;
  logic [PW-1:0]       last_grant;
  logic [PW-1:0]       port_q;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   val_q;
  logic [NPORTS-1:0]   done_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [NPORTS-1:0]   eligible_c;
  logic                grant_vld_c;
  logic [PW-1:0]       grant_c;
  logic [1:0]          sel_func_c;
  logic [ADDR_W-1:0]   sel_addr_c;
  logic [DATA_W-1:0]   sel_wdata_c;
  logic [ADDR_W:0]     sum_c;

  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

  // Round-robin pick: closest eligible port after last_grant wins (descending loop, last write wins).
  always_comb begin
    eligible_c  = bus.req & ~done_q;
    grant_vld_c = 1'b0;
    grant_c     = '0;
    for (int unsigned i = NPORTS; i >= 1; i--) begin
      if (eligible_c[PW'((32'(last_grant) + i) % NPORTS)]) begin
        grant_vld_c = 1'b1;
        grant_c     = PW'((32'(last_grant) + i) % NPORTS);
      end
    end
    sel_func_c  = bus.func[32'(grant_c)*2 +: 2];
    sel_addr_c  = bus.addr[32'(grant_c)*ADDR_W +: ADDR_W];
    sel_wdata_c = bus.wdata[32'(grant_c)*DATA_W +: DATA_W];
    sum_c       = {1'b0, free_ptr} + {1'b0, val_q};
  end

`ifdef MEM_UNIT_GC_REQ_EN
  logic          retried_q;
  logic          free_vld_c;
  logic [PW-1:0] free_c;
  logic [ADDR_W-1:0] free_val_c;

  // While the allocator is parked, a SET_FREE from any other port is serviced in place.
  always_comb begin
    free_vld_c = 1'b0;
    free_c     = '0;
    free_val_c = '0;
    for (int i = int'(NPORTS) - 1; i >= 0; i--) begin
      if (eligible_c[i] && bus.func[2*i +: 2] == OP_FREE && PW'(i) != port_q) begin
        free_vld_c = 1'b1;
        free_c     = PW'(i);
        free_val_c = bus.wdata[i*int'(DATA_W) +: ADDR_W];
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INIT_RD;
      last_grant <= PW'(NPORTS - 1);
      port_q     <= '0;
      op_q       <= '0;
      val_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      ready      <= 1'b0;
      free_ptr   <= '0;
      mem_addr   <= '0;
      mem_wren   <= 1'b0;
      mem_wdata  <= '0;
`ifdef MEM_UNIT_GC_REQ_EN
      gc_req     <= 1'b0;
      retried_q  <= 1'b0;
`endif
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      unique case (state)
        INIT_RD: begin
          mem_addr <= '0;
          state    <= INIT_WAIT;
        end
        INIT_WAIT: state <= INIT_CLEAR;
        INIT_CLEAR: begin
          free_ptr  <= mem_rdata[ADDR_W-1:0];
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_wren  <= 1'b1;
          state     <= INIT_DONE;
        end
        INIT_DONE: begin
          mem_wren <= 1'b0;
          ready    <= 1'b1;
          state    <= IDLE;
        end
        IDLE: begin
          if (grant_vld_c) begin
            last_grant <= grant_c;
            port_q     <= grant_c;
            op_q       <= sel_func_c;
            val_q      <= sel_wdata_c[ADDR_W-1:0];
            ready      <= 1'b0;
`ifdef MEM_UNIT_GC_REQ_EN
            retried_q  <= 1'b0;
`endif
            if (sel_func_c == OP_GET) begin
              mem_addr <= sel_addr_c;
              state    <= READ_WAIT;
            end else if (sel_func_c == OP_SET) begin
              mem_addr  <= sel_addr_c;
              mem_wdata <= sel_wdata_c;
              mem_wren  <= 1'b1;
              state     <= WRITE_DONE;
            end else begin
              state <= ALLOC;
            end
          end
        end
        READ_WAIT: state <= READ_CAP;
        READ_CAP: begin
          rdata_q        <= mem_rdata;
          done_q[port_q] <= 1'b1;
          ready          <= 1'b1;
          state          <= IDLE;
        end
        WRITE_DONE: begin
          mem_wren       <= 1'b0;
          done_q[port_q] <= 1'b1;
          ready          <= 1'b1;
          state          <= IDLE;
        end
        ALLOC: begin
          if (op_q == OP_FREE) begin
            free_ptr       <= val_q;
            rdata_q        <= '0;
            done_q[port_q] <= 1'b1;
            ready          <= 1'b1;
            state          <= IDLE;
          end else if (!sum_c[ADDR_W]) begin
            rdata_q        <= DATA_W'(free_ptr);
            free_ptr       <= sum_c[ADDR_W-1:0];
            done_q[port_q] <= 1'b1;
            ready          <= 1'b1;
            state          <= IDLE;
          end
`ifdef MEM_UNIT_GC_REQ_EN
          else if (!retried_q) begin
            gc_req <= 1'b1;
            state  <= GC_WAIT;
          end
`endif
          else begin
            rdata_q        <= '0;
            err_q          <= 1'b1;
            done_q[port_q] <= 1'b1;
            ready          <= 1'b1;
            state          <= IDLE;
          end
        end
`ifdef MEM_UNIT_GC_REQ_EN
        GC_WAIT: begin
          if (free_vld_c) begin
            free_ptr       <= free_val_c;
            rdata_q        <= '0;
            done_q[free_c] <= 1'b1;
          end
          if (gc_done) begin
            gc_req    <= 1'b0;
            retried_q <= 1'b1;
            state     <= ALLOC;
          end
        end
`endif
        default: state <= INIT_RD;
      endcase
    end
  end
endmodule

// File: tb/tb_multiport_memory_unit.sv
// Randomized bench for multiport_memory_unit against an array/arithmetic reference model.
module tb_multiport_memory_unit;
  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 64;
  localparam int unsigned NP    = 2;
  localparam int          DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          ready;
  logic [AW-1:0] free_ptr;
  logic [AW-1:0] mem_addr;
  logic          mem_wren;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef MEM_UNIT_GC_REQ_EN
  logic          gc_req;
  logic          gc_done;
`endif

  multiport_memory_unit_if #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus();

  multiport_memory_unit #(.ADDR_W(AW), .DATA_W(DW), .NPORTS(NP)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ready     (ready),
    .free_ptr  (free_ptr),
    .mem_addr  (mem_addr),
    .mem_wren  (mem_wren),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef MEM_UNIT_GC_REQ_EN
    ,
    .gc_req    (gc_req),
    .gc_done   (gc_done)
`endif
  );

  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [AW-1:0] ref_fp;
  int            ref_last;
  int            n_checks;
  int            n_errs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External synchronous RAM: registered read of the presented address.
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Release reset at #1 after an edge and count edges until ready rises.
  task automatic release_and_init(input logic [AW-1:0] seed);
    int cyc;
    rst = 1'b0;
    cyc = 0;
    while (!ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ready_edge", 64'(cyc), 64'd4);
    check("init_free_ptr", 64'(free_ptr), 64'(seed));
    ref_fp     = seed;
    ref_mem[0] = '0;
    ref_last   = NP - 1;
  endtask

  // Issue one op on a lone port, predict its outcome from the model and compare.
  task automatic do_op(input int p, input logic [1:0] f, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int            cyc;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
    logic [AW-1:0] exp_fp;
    logic          chk_rd;
    exp_err = 1'b0;
    exp_fp  = ref_fp;
    exp_rd  = '0;
    chk_rd  = 1'b1;
    case (f)
      2'b00: exp_rd = ref_mem[a];
      2'b01: begin ref_mem[a] = d; chk_rd = 1'b0; end
      2'b10: begin
        if (int'(ref_fp) + int'(d[AW-1:0]) < DEPTH) begin
          exp_rd = DW'(ref_fp);
          exp_fp = AW'(int'(ref_fp) + int'(d[AW-1:0]));
        end else begin
          exp_err = 1'b1;
        end
      end
      default: exp_fp = d[AW-1:0];
    endcase
    @(posedge clk); #1;
    check("ready_idle", 64'(ready), 64'd1);
    bus.func[p*2 +: 2]   = f;
    bus.addr[p*AW +: AW] = a;
    bus.wdata[p*DW +: DW] = d;
    bus.req[p]           = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (bus.done == '0 && cyc < 20);
    bus.req[p] = 1'b0;
    check("latency", 64'(cyc), (f == 2'b00) ? 64'd3 : 64'd2);
    check("done_port", 64'(bus.done), 64'(1 << p));
    check("err", 64'(bus.err), 64'(exp_err));
    if (chk_rd) check("rdata", bus.rdata, exp_rd);
    check("free_ptr", 64'(free_ptr), 64'(exp_fp));
    ref_fp   = exp_fp;
    ref_last = p;
  endtask

  initial begin
    int            cyc;
    int            cnt;
    int            exp_port;
    logic [1:0]    f;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [AW-1:0] rr_addr [NP];

    n_checks = 0;
    n_errs   = 0;
    bus.req   = '0;
    bus.func  = '0;
    bus.addr  = '0;
    bus.wdata = '0;
`ifdef MEM_UNIT_GC_REQ_EN
    gc_done = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
    ram[0] = 64'h0123;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_rdata", bus.rdata, 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_free_ptr", 64'(free_ptr), 64'd0);
    check("rst_mem_wren", 64'(mem_wren), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    release_and_init(10'h123);
    do_op(0, 2'b00, 10'h000, '0);

    // Directed write/read, allocation and boundary cases
    do_op(0, 2'b01, 10'h050, 64'hDEADBEEF);
    do_op(1, 2'b00, 10'h050, '0);
    do_op(1, 2'b11, '0, 64'h100);
    do_op(0, 2'b10, '0, 64'd4);
    do_op(1, 2'b10, '0, 64'd4);
    do_op(0, 2'b10, '0, 64'd0);
    do_op(0, 2'b11, '0, 64'h3FE);
    do_op(1, 2'b10, '0, 64'd1);
    do_op(1, 2'b11, '0, 64'h3FE);
`ifdef MEM_UNIT_GC_REQ_EN
    @(posedge clk); #1;
    bus.func[1:0] = 2'b10;
    bus.wdata[DW-1:0] = 64'd2;
    bus.req[0] = 1'b1;
    cyc = 0;
    while (!gc_req && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("gc_req_rise", 64'(gc_req), 64'd1);
    bus.func[3:2] = 2'b11;
    bus.wdata[DW +: DW] = 64'h010;
    bus.req[1] = 1'b1;
    cyc = 0;
    while (bus.done == '0 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    bus.req[1] = 1'b0;
    check("gc_setfree_done", 64'(bus.done), 64'd2);
    check("gc_setfree_ptr", 64'(free_ptr), 64'h010);
    gc_done = 1'b1;
    @(posedge clk); #1;
    gc_done = 1'b0;
    check("gc_req_drop", 64'(gc_req), 64'd0);
    cyc = 0;
    while (bus.done == '0 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    bus.req[0] = 1'b0;
    check("gc_retry_done", 64'(bus.done), 64'd1);
    check("gc_retry_err", 64'(bus.err), 64'd0);
    check("gc_retry_rdata", bus.rdata, 64'h010);
    check("gc_retry_ptr", 64'(free_ptr), 64'h012);
    ref_fp   = 10'h012;
    ref_last = 0;
`else
    do_op(0, 2'b10, '0, 64'd2);
`endif

    // Randomized traffic
    for (int k = 0; k < 60; k++) begin
      f = 2'($urandom_range(0, 3));
      a = AW'($urandom_range(0, DEPTH - 1));
      d = {$urandom, $urandom};
      if (f == 2'b10)
        d = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, DEPTH - 1)) : DW'($urandom_range(0, 16));
      if (f == 2'b11)
        d = ($urandom_range(0, 2) == 0) ? DW'(DEPTH - 1 - int'($urandom_range(0, 8))) : DW'($urandom_range(0, DEPTH - 1));
`ifdef MEM_UNIT_GC_REQ_EN
      if (f == 2'b10 && int'(ref_fp) + int'(d[AW-1:0]) >= DEPTH) f = 2'b00;
`endif
      do_op(int'($urandom_range(0, NP - 1)), f, a, d);
    end

    // Both ports read continuously: grants must alternate
    do_op(1, 2'b01, 10'h0A5, 64'h5A5A_1234_0000_FFFF);
    rr_addr[0] = 10'h050;
    rr_addr[1] = 10'h0A5;
    @(posedge clk); #1;
    exp_port = (ref_last + 1) % NP;
    for (int p = 0; p < NP; p++) begin
      bus.func[p*2 +: 2]   = 2'b00;
      bus.addr[p*AW +: AW] = rr_addr[p];
    end
    bus.req = '1;
    cnt = 0;
    cyc = 0;
    while (cnt < 6 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done != '0) begin
        check("rr_port", 64'(bus.done), 64'(1 << exp_port));
        check("rr_rdata", bus.rdata, ref_mem[rr_addr[exp_port]]);
        exp_port = (exp_port + 1) % NP;
        cnt++;
      end
    end
    bus.req = '0;
    check("rr_count", 64'(cnt), 64'd6);
    ref_last = exp_port;
    repeat (5) @(posedge clk);

    // Reset during a write: wren drops at once, write is lost, init reruns
    @(posedge clk); #1;
    bus.func[1:0]     = 2'b01;
    bus.addr[AW-1:0]  = 10'h077;
    bus.wdata[DW-1:0] = 64'hCAFE_F00D;
    bus.req[0]        = 1'b1;
    @(posedge clk); #1;
    check("wren_before_rst", 64'(mem_wren), 64'd1);
    rst = 1'b1;
    bus.req = '0;
    ram[0] = 64'h02AB;
    #1;
    check("wren_async_drop", 64'(mem_wren), 64'd0);
    check("rst_ready_mid", 64'(ready), 64'd0);
    check("rst_free_ptr_mid", 64'(free_ptr), 64'd0);
    @(posedge clk); #1;
    release_and_init(10'h2AB);
    do_op(0, 2'b00, 10'h077, '0);
    do_op(1, 2'b00, 10'h000, '0);
    do_op(0, 2'b10, '0, 64'd3);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
